// File: rtl/bcd_timer_ctrl.sv
// Sequencing controller for a two-digit BCD up/down counter: turns load/start/stop
// commands and a periodic tick into CE/PE/UP/D/MAX and reports terminal-count completion.
module bcd_timer_ctrl #(
  parameter logic [7:0] LIMIT_DEF = 8'h99
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic       dir_up,
  input  logic [7:0] preset,
  input  logic [7:0] limit,
  input  logic [7:0] Q,
  output logic       CE,
  output logic       PE,
  output logic       UP,
  output logic [7:0] D,
  output logic [7:0] MAX,
  output logic       busy,
  output logic       done,
  output logic       alarm,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_up;
  logic [7:0] r_d;
  logic [7:0] r_max;
  logic       r_alarm;
  logic       r_err;

  logic       w_at_term;
  logic       w_preset_ok;
  logic       w_cmd_stop;
  logic       w_cmd_load;
  logic       w_cmd_start;
  logic       w_latch;
  logic       w_err;

  assign w_at_term   = (r_up && (Q == r_max)) || (!r_up && (Q == 8'h00));
  assign w_preset_ok = (preset[7:4] <= 4'd9) && (preset[3:0] <= 4'd9);

  // Only the highest-priority pulse in a cycle is acted on: stop > load > start.
  assign w_cmd_stop  = stop;
  assign w_cmd_load  = !stop && load;
  assign w_cmd_start = !stop && !load && start;

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_load) begin
          if (w_preset_ok) begin
            w_latch = 1'b1;
            w_next  = S_LOAD;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_cmd_start) begin
          if (w_at_term) w_err = 1'b1;
          else           w_next = S_RUN;
        end
      end
      S_LOAD: w_next = S_IDLE;
      S_RUN: begin
        if (w_cmd_stop)     w_next = S_PAUSE;
        else if (w_at_term) w_next = S_DONE;
      end
      S_PAUSE: begin
        if (w_cmd_stop) begin
          w_next = S_IDLE;
        end else if (w_cmd_load) begin
          if (w_preset_ok) begin
            w_latch = 1'b1;
            w_next  = S_LOAD;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_cmd_start) begin
          w_next = S_RUN;
        end
      end
      S_DONE: begin
        if (w_cmd_stop) begin
          w_next = S_IDLE;
        end else if (w_cmd_load) begin
          if (w_preset_ok) begin
            w_latch = 1'b1;
            w_next  = S_LOAD;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_cmd_start) begin
          w_err = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      r_state <= S_IDLE;
      r_up    <= 1'b1;
      r_d     <= 8'h00;
      r_max   <= LIMIT_DEF;
      r_alarm <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_alarm <= (w_next == S_DONE) && (r_state != S_DONE);
      r_err   <= w_err;
      if (w_latch) begin
        r_d   <= preset;
        r_up  <= dir_up;
        r_max <= limit;
      end
    end
  end

  // Gating on the terminal value keeps the counter from ever stepping past it.
  assign CE    = (r_state == S_RUN) && tick && !w_at_term;
  assign PE    = (r_state == S_LOAD);
  assign UP    = r_up;
  assign D     = r_d;
  assign MAX   = r_max;
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign alarm = r_alarm;
  assign err   = r_err;
  assign state = r_state;

endmodule
